// File: rtl/st_frame_to_onchip_writer_if.sv
// Stream sink plus on-chip RAM write port for the frame writer.
// slave = the writer itself; master = the stream source / RAM side.
interface st_frame_to_onchip_writer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 15
);
    logic [DATA_W-1:0] snk_data;
    logic              snk_valid;
    logic              snk_sop;
    logic              snk_eop;
    logic              snk_ready;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_clken;

    modport slave (
        input  snk_data, snk_valid, snk_sop, snk_eop,
        output snk_ready,
        output mem_address, mem_chipselect, mem_write, mem_byteenable,
        output mem_writedata, mem_clken
    );

    modport master (
        output snk_data, snk_valid, snk_sop, snk_eop,
        input  snk_ready,
        input  mem_address, mem_chipselect, mem_write, mem_byteenable,
        input  mem_writedata, mem_clken
    );
endinterface

// File: rtl/st_frame_to_onchip_writer.sv
// Captures one armed Avalon-ST frame into on-chip RAM from word 0; ST_FRAME_WRITER_BYTESWAP_EN byte-reverses data.
// Latency: RAM write 1 cycle after beat acceptance, frame_done 1 cycle after the last write strobe.
// Backpressure: snk_ready is high whenever armed; the sink never stalls an armed frame (full rate).
module st_frame_to_onchip_writer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 15,
    parameter int DEPTH  = 25000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        arm,
    input  logic                        abort,
    st_frame_to_onchip_writer_if.slave  bus,
    output logic                        busy,
    output logic                        frame_done,
    output logic [ADDR_W:0]             word_count,
    output logic                        overflow
);
    typedef enum logic [1:0] {IDLE, HUNT, WRITE, DRAIN} state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_t            state;
    logic [ADDR_W:0]   cnt;
    logic              done_pend;
    logic              beat;
    logic [ADDR_W:0]   beat_addr;
    logic [DATA_W-1:0] wdata;

    assign beat      = bus.snk_valid & bus.snk_ready;
    // A sop beat always restarts the frame at word 0, in HUNT or mid-frame.
    assign beat_addr = bus.snk_sop ? '0 : cnt;

`ifdef ST_FRAME_WRITER_BYTESWAP_EN
    function automatic logic [DATA_W-1:0] swap_bytes(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_W/8; i++) begin
            r[8*i +: 8] = d[DATA_W-8-8*i +: 8];
        end
        return r;
    endfunction
    assign wdata = swap_bytes(bus.snk_data);
`else
    assign wdata = bus.snk_data;
`endif

    assign bus.mem_byteenable = 4'hF;
    assign bus.mem_clken      = 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            cnt                <= '0;
            done_pend          <= 1'b0;
            bus.snk_ready      <= 1'b0;
            bus.mem_address    <= '0;
            bus.mem_chipselect <= 1'b0;
            bus.mem_write      <= 1'b0;
            bus.mem_writedata  <= '0;
            busy               <= 1'b0;
            frame_done         <= 1'b0;
            word_count         <= '0;
            overflow           <= 1'b0;
        end else begin
            bus.mem_chipselect <= 1'b0;
            bus.mem_write      <= 1'b0;
            frame_done         <= done_pend;
            done_pend          <= 1'b0;

            case (state)
                IDLE: begin
                    if (arm && !abort) begin
                        state         <= HUNT;
                        bus.snk_ready <= 1'b1;
                        busy          <= 1'b1;
                        overflow      <= 1'b0;
                        cnt           <= '0;
                    end
                end

                default: begin
                    if (abort) begin
                        // Abort beats a same-cycle beat; any write already registered still goes out.
                        state         <= IDLE;
                        bus.snk_ready <= 1'b0;
                        busy          <= 1'b0;
                    end else if (beat) begin
                        if (state == DRAIN) begin
                            if (bus.snk_eop) begin
                                word_count    <= DEPTH_C;
                                done_pend     <= 1'b1;
                                state         <= IDLE;
                                bus.snk_ready <= 1'b0;
                                busy          <= 1'b0;
                            end
                        end else if (state == HUNT && !bus.snk_sop) begin
                            state <= HUNT;
                        end else if (beat_addr == DEPTH_C) begin
                            overflow <= 1'b1;
                            if (bus.snk_eop) begin
                                word_count    <= DEPTH_C;
                                done_pend     <= 1'b1;
                                state         <= IDLE;
                                bus.snk_ready <= 1'b0;
                                busy          <= 1'b0;
                            end else begin
                                state <= DRAIN;
                            end
                        end else begin
                            bus.mem_chipselect <= 1'b1;
                            bus.mem_write      <= 1'b1;
                            bus.mem_address    <= beat_addr[ADDR_W-1:0];
                            bus.mem_writedata  <= wdata;
                            cnt                <= beat_addr + 1'b1;
                            if (bus.snk_eop) begin
                                word_count    <= beat_addr + 1'b1;
                                done_pend     <= 1'b1;
                                state         <= IDLE;
                                bus.snk_ready <= 1'b0;
                                busy          <= 1'b0;
                            end else begin
                                state <= WRITE;
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_st_frame_to_onchip_writer.sv
// Bench for st_frame_to_onchip_writer: per-cycle compare against a frame-level model plus literal checks.
module tb_st_frame_to_onchip_writer;
    localparam int DEPTH = 25000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic        busy;
    logic        frame_done;
    logic [15:0] word_count;
    logic        overflow;

    st_frame_to_onchip_writer_if #(.DATA_W(32), .ADDR_W(15)) bus ();

    st_frame_to_onchip_writer dut (
        .clk        (clk),
        .reset      (reset),
        .arm        (arm),
        .abort      (abort),
        .bus        (bus.slave),
        .busy       (busy),
        .frame_done (frame_done),
        .word_count (word_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] lit(input logic [31:0] d);
`ifdef ST_FRAME_WRITER_BYTESWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    // Frame-level model: what the outputs must be after each clock edge.
    logic        e_ready = 0, e_busy = 0, e_write = 0, e_done = 0, e_ovf = 0;
    logic [14:0] e_addr = 0;
    logic [31:0] e_data = 0;
    logic [15:0] e_wc = 0;
    bit          pend = 0, hunting = 0, dropping = 0;
    int          cnt = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            e_ready = 0; e_busy = 0; e_write = 0; e_done = 0; e_ovf = 0;
            e_addr = 0; e_data = 0; e_wc = 0;
            pend = 0; hunting = 0; dropping = 0; cnt = 0;
        end else begin
            int a;
            bit acc;
            acc     = bus.snk_valid && e_ready;
            e_write = 0;
            e_done  = pend;
            pend    = 0;
            if (!e_busy) begin
                if (arm && !abort) begin
                    e_busy = 1; hunting = 1; dropping = 0; e_ovf = 0; cnt = 0;
                end
            end else if (abort) begin
                e_busy = 0; hunting = 0; dropping = 0;
            end else if (acc) begin
                if (dropping) begin
                    if (bus.snk_eop) begin
                        e_wc = DEPTH; pend = 1; e_busy = 0; dropping = 0;
                    end
                end else if (!(hunting && !bus.snk_sop)) begin
                    hunting = 0;
                    a = bus.snk_sop ? 0 : cnt;
                    if (a >= DEPTH) begin
                        e_ovf = 1;
                        if (bus.snk_eop) begin
                            e_wc = DEPTH; pend = 1; e_busy = 0;
                        end else dropping = 1;
                    end else begin
                        e_write = 1;
                        e_addr  = a[14:0];
                        e_data  = lit(bus.snk_data);
                        cnt     = a + 1;
                        if (bus.snk_eop) begin
                            e_wc = 16'(a + 1); pend = 1; e_busy = 0;
                        end
                    end
                end
            end
            e_ready = e_busy;
        end
    end

    // Captured RAM contents and write/done bookkeeping.
    logic [31:0] ram [0:DEPTH-1];
    int          n_wr = 0, n_done = 0, last_addr = -1;
    int          log_addr [$];
    logic [31:0] log_data [$];

    always @(negedge clk) begin
        if (!reset) begin
            chk("snk_ready", 64'(bus.snk_ready), 64'(e_ready));
            chk("busy", 64'(busy), 64'(e_busy));
            chk("mem_write", 64'(bus.mem_write), 64'(e_write));
            chk("mem_chipselect", 64'(bus.mem_chipselect), 64'(e_write));
            chk("frame_done", 64'(frame_done), 64'(e_done));
            chk("word_count", 64'(word_count), 64'(e_wc));
            chk("overflow", 64'(overflow), 64'(e_ovf));
            chk("mem_byteenable", 64'(bus.mem_byteenable), 64'h0F);
            chk("mem_clken", 64'(bus.mem_clken), 64'h1);
            if (e_write) begin
                chk("mem_address", 64'(bus.mem_address), 64'(e_addr));
                chk("mem_writedata", 64'(bus.mem_writedata), 64'(e_data));
            end
            if (bus.mem_write) begin
                if (int'(bus.mem_address) < DEPTH) ram[bus.mem_address] = bus.mem_writedata;
                last_addr = int'(bus.mem_address);
                log_addr.push_back(last_addr);
                log_data.push_back(bus.mem_writedata);
                n_wr++;
            end
            if (frame_done) n_done++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.snk_valid = 0; bus.snk_sop = 0; bus.snk_eop = 0;
        arm = 0; abort = 0;
    endtask

    task automatic beat(input logic [31:0] d, input logic s, input logic e);
        bus.snk_valid = 1; bus.snk_data = d; bus.snk_sop = s; bus.snk_eop = e;
        tick();
    endtask

    task automatic do_arm();
        idle_in();
        arm = 1;
        tick();
        arm = 0;
    endtask

    task automatic settle(input int n);
        idle_in();
        repeat (n) tick();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " snk_ready"}, 64'(bus.snk_ready), 0);
        chk({tag, " mem_chipselect"}, 64'(bus.mem_chipselect), 0);
        chk({tag, " mem_write"}, 64'(bus.mem_write), 0);
        chk({tag, " frame_done"}, 64'(frame_done), 0);
        chk({tag, " overflow"}, 64'(overflow), 0);
        chk({tag, " busy"}, 64'(busy), 0);
        chk({tag, " mem_address"}, 64'(bus.mem_address), 0);
        chk({tag, " mem_writedata"}, 64'(bus.mem_writedata), 0);
        chk({tag, " word_count"}, 64'(word_count), 0);
        chk({tag, " mem_byteenable"}, 64'(bus.mem_byteenable), 64'hF);
        chk({tag, " mem_clken"}, 64'(bus.mem_clken), 1);
    endtask

    initial begin
        int w0, d0;
        bus.snk_data = 0;
        idle_in();
        #8;
        chk_reset_values("reset");
        #4 reset = 0;
        settle(2);

        // Basic 4-beat frame at full rate.
        w0 = n_wr; d0 = n_done;
        do_arm();
        beat(32'h11111111, 1, 0);
        beat(32'h22222222, 0, 0);
        beat(32'h33333333, 0, 0);
        beat(32'h44444444, 0, 1);
        settle(4);
        chk("t1 ram0", 64'(ram[0]), 64'(lit(32'h11111111)));
        chk("t1 ram3", 64'(ram[3]), 64'(lit(32'h44444444)));
        chk("t1 writes", 64'(n_wr - w0), 4);
        chk("t1 done pulses", 64'(n_done - d0), 1);
        chk("t1 word_count", 64'(word_count), 4);
        chk("t1 busy", 64'(busy), 0);

        // Stream before arm, then non-sop beats while hunting.
        w0 = n_wr;
        beat(32'hBAD00001, 1, 0);
        beat(32'hBAD00002, 0, 1);
        do_arm();
        beat(32'hBAD00003, 0, 0);
        beat(32'hBAD00004, 0, 0);
        beat(32'h5A5A0001, 1, 0);
        beat(32'h5A5A0002, 0, 1);
        settle(4);
        chk("t2 writes", 64'(n_wr - w0), 2);
        chk("t2 first addr", 64'(log_addr[w0]), 0);
        chk("t2 first data", 64'(log_data[w0]), 64'(lit(32'h5A5A0001)));
        chk("t2 word_count", 64'(word_count), 2);

        // Overflowing frame of DEPTH+2 beats.
        w0 = n_wr; d0 = n_done;
        do_arm();
        for (int i = 0; i < DEPTH + 2; i++)
            beat(32'hC0000000 | 32'(i), i == 0, i == DEPTH + 1);
        settle(4);
        chk("t3 last addr", 64'(last_addr), 24999);
        chk("t3 writes", 64'(n_wr - w0), 25000);
        chk("t3 last data", 64'(ram[24999]), 64'(lit(32'hC00061A7)));
        chk("t3 overflow", 64'(overflow), 1);
        chk("t3 word_count", 64'(word_count), 25000);
        chk("t3 done pulses", 64'(n_done - d0), 1);

        // Restart mid-frame with a second sop.
        d0 = n_done;
        do_arm();
        for (int i = 0; i < 10; i++) beat(32'hD0 + 32'(i), i == 0, 0);
        beat(32'hAAAA5555, 1, 0);
        beat(32'hBBBB0001, 0, 0);
        beat(32'hBBBB0002, 0, 0);
        beat(32'hBBBB0003, 0, 1);
        settle(4);
        chk("t4 ram0", 64'(ram[0]), 64'(lit(32'hAAAA5555)));
        chk("t4 ram3", 64'(ram[3]), 64'(lit(32'hBBBB0003)));
        chk("t4 word_count", 64'(word_count), 4);
        chk("t4 overflow", 64'(overflow), 0);
        chk("t4 done pulses", 64'(n_done - d0), 1);

        // Abort mid-frame, with a beat on the abort cycle.
        w0 = n_wr; d0 = n_done;
        do_arm();
        for (int i = 0; i < 5; i++) beat(32'hE0 + 32'(i), i == 0, 0);
        abort = 1;
        beat(32'hEEEEEEEE, 0, 1);
        settle(4);
        chk("t5 busy", 64'(busy), 0);
        chk("t5 writes", 64'(n_wr - w0), 5);
        chk("t5 done pulses", 64'(n_done - d0), 0);
        chk("t5 word_count", 64'(word_count), 4);
        arm = 1; abort = 1;
        tick();
        chk("t5 arm+abort busy", 64'(busy), 0);
        chk("t5 arm+abort ready", 64'(bus.snk_ready), 0);
        settle(2);

        // Single-word frame (sop and eop together).
        do_arm();
        beat(32'h12345678, 1, 1);
        settle(4);
`ifdef ST_FRAME_WRITER_BYTESWAP_EN
        chk("t6 ram0", 64'(ram[0]), 64'h78563412);
`else
        chk("t6 ram0", 64'(ram[0]), 64'h12345678);
`endif
        chk("t6 word_count", 64'(word_count), 1);

        // Reset asserted mid-frame, then recovery.
        do_arm();
        beat(32'hF0000001, 1, 0);
        beat(32'hF0000002, 0, 0);
        bus.snk_valid = 1; bus.snk_data = 32'hF0000003;
        @(posedge clk);
        #3 reset = 1;
        #1 chk_reset_values("midreset");
        settle(2);
        reset = 0;
        settle(2);
        do_arm();
        beat(32'h0000BEEF, 1, 0);
        beat(32'h0000CAFE, 0, 1);
        settle(4);
        chk("t7 word_count", 64'(word_count), 2);
        chk("t7 ram1", 64'(ram[1]), 64'(lit(32'h0000CAFE)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/st_frame_to_onchip_writer.md
Name: st_frame_to_onchip_writer

Overview:
- Upstream feeder for the 32-bit single-port on-chip RAM (25000 words, 15-bit word address, 1-cycle write).
- Accepts one packet (frame) of 32-bit words on an Avalon-ST sink and writes it to sequential RAM addresses starting at word 0.
- Reports completion, word count and overflow to the control side.
- Armed by software/Qsys logic once per frame, so a frame lands in RAM only when requested.

Parameters:
- DATA_W, 32, stream and RAM data width
- ADDR_W, 15, RAM word-address width
- DEPTH, 25000, RAM words usable; writes at address >= DEPTH are forbidden

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- arm  in  1  single-cycle request to capture the next frame
- abort  in  1  single-cycle request to abandon the current capture
- snk_data  in  DATA_W  stream word
- snk_valid  in  1  stream word valid
- snk_sop  in  1  start of packet, qualified by snk_valid
- snk_eop  in  1  end of packet, qualified by snk_valid
- snk_ready  out  1  sink ready; a beat transfers when snk_valid & snk_ready
- mem_address  out  ADDR_W  RAM word address
- mem_chipselect  out  1  RAM select
- mem_write  out  1  RAM write strobe
- mem_byteenable  out  4  RAM byte lanes
- mem_writedata  out  DATA_W  RAM write data
- mem_clken  out  1  RAM clock enable
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse when a frame completes
- word_count  out  ADDR_W+1  words written in the last frame
- overflow  out  1  sticky flag: the frame exceeded DEPTH

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - snk_ready, mem_chipselect, mem_write, frame_done, overflow, busy = 0.
  - mem_address, mem_writedata, word_count = 0.
  - mem_byteenable = 4'hF; mem_clken = 1.
- mem_byteenable is constant 4'hF and mem_clken is constant 1 outside reset.
- FSM states: IDLE, HUNT, WRITE, DRAIN.
- IDLE:
  - snk_ready = 0.
  - arm -> HUNT; clear overflow and the internal address counter.
- HUNT:
  - snk_ready = 1.
  - Beats without sop are accepted and discarded.
  - A beat with sop is written to address 0; counter = 1; go to WRITE.
  - sop & eop on the same beat -> single-word frame: write it, then follow the WRITE eop rules.
- WRITE:
  - snk_ready = 1.
  - Each accepted beat is written at the counter value, then the counter increments.
  - Beat with eop:
    - it is written;
    - word_count latches counter+1;
    - frame_done pulses on the cycle after the RAM write strobe;
    - go to IDLE.
  - Beat with sop (restart mid-frame): the beat is written at address 0 and the counter is set to 1; the earlier partial frame is discarded logically.
  - Accepted beat while counter == DEPTH, not eop:
    - the beat is dropped (no RAM write);
    - overflow is set;
    - go to DRAIN.
  - Accepted eop beat while counter == DEPTH:
    - no write; overflow is set;
    - word_count = DEPTH;
    - frame_done pulses; go to IDLE.
- DRAIN:
  - snk_ready = 1; beats are discarded.
  - eop -> word_count = DEPTH, frame_done pulse, go to IDLE.
- Write timing:
  - RAM write outputs are registered; mem_chipselect = mem_write = 1 for exactly one cycle, the cycle after the beat is accepted.
  - Throughput is one word per clk with no bubbles.
  - Maximum address driven is DEPTH-1; addresses never wrap.
- abort in HUNT/WRITE/DRAIN:
  - go to IDLE next cycle with no frame_done; word_count is unchanged.
  - A write already registered still completes.
  - abort takes priority over a beat on the same cycle; that beat is not written.
- arm while busy is ignored. arm and abort together in IDLE: abort wins, stay in IDLE.
- Reset asserted mid-frame forces the reset values immediately; the RAM contents written so far are left as they are.

Optional Feature:
- Macro: ST_FRAME_WRITER_BYTESWAP_EN.
- Defined: mem_writedata = byte-reversed snk_data ({b0,b1,b2,b3}), for big-endian pixel sources.
- Undefined: snk_data passes to mem_writedata unchanged.
- Timing and control are identical in both builds.

Test Plan:
- arm, then 4-beat frame 0x11111111..0x44444444 (sop on beat 1, eop on beat 4) at full rate -> writes at addresses 0..3 on consecutive cycles; word_count = 4; one frame_done pulse; busy = 0 afterwards.
- Stream before arm, then arm with 2 non-sop beats before sop -> no mem_write until the sop beat; the sop beat lands at address 0.
- arm, then 25002-beat frame -> last write at address 24999; overflow = 1; no further writes; word_count = 25000; frame_done on eop.
- arm, 10 beats, then a sop beat 0xAAAA5555 mid-frame, then 3 more beats with eop -> 0xAAAA5555 at address 0; word_count = 4.
- arm, 5 beats, abort -> state IDLE, no frame_done, word_count keeps its previous value; reset asserted mid-frame -> all outputs at reset values within the same cycle.
- With ST_FRAME_WRITER_BYTESWAP_EN: beat 0x12345678 -> mem_writedata = 0x78563412.
